// File: rtl/traffic_pkg.sv
// Shared defaults and per-channel status type for the traffic sensor front end.
package traffic_pkg;

    localparam int TL_DEBOUNCE_DEF = 4;
    localparam int TL_STUCK_DEF    = 1000;

    typedef struct packed {
        logic req;
        logic fault;
    } chan_status_t;

endpackage

// File: rtl/traffic_sensor_channel.sv
// One sensor channel: two-flop synchroniser, debounce, request latch with
// serve clear, and stuck-high detection.
module traffic_sensor_channel
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = TL_DEBOUNCE_DEF,
    parameter int STUCK_LIMIT     = TL_STUCK_DEF
) (
    input  logic clk,
    input  logic rstb,
    input  logic raw,
    input  logic serve,
    output logic req,
    output logic fault
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STUCK_LIMIT + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCNT_MAX  = SW'(STUCK_LIMIT);

    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          req_q, req_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          fault_q, fault_d;
    logic          rise;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (s2_q == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            deb_d  = s2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end

        // A new arrival outranks a serve in the same cycle so no car is lost.
        rise  = deb_d & ~deb_q;
        req_d = rise | (req_q & ~serve);

        if (!deb_q) begin
            scnt_d = '0;
        end else if (scnt_q == SCNT_MAX) begin
            scnt_d = scnt_q;
        end else begin
            scnt_d = scnt_q + 1'b1;
        end

        // Fault drops on the same edge the debounced level falls.
        fault_d = deb_d & (fault_q | (deb_q & (scnt_d == SCNT_MAX)));
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            req_q   <= 1'b0;
            scnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            req_q   <= req_d;
            scnt_q  <= scnt_d;
            fault_q <= fault_d;
        end
    end

    assign req   = req_q;
    assign fault = fault_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions road A/B vehicle sensors into clean request and fault bits
// for the traffic light FSM.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = TL_DEBOUNCE_DEF,
    parameter int STUCK_LIMIT     = TL_STUCK_DEF
) (
    input  logic clk,
    input  logic rstb,
    input  logic sensor_a_raw,
    input  logic sensor_b_raw,
    input  logic serve_a,
    input  logic serve_b,
    output logic input_a,
    output logic input_b,
    output logic fault_a,
    output logic fault_b
);

    chan_status_t st_a, st_b;

    traffic_sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_LIMIT    (STUCK_LIMIT)
    ) u_chan_a (
        .clk  (clk),
        .rstb (rstb),
        .raw  (sensor_a_raw),
        .serve(serve_a),
        .req  (st_a.req),
        .fault(st_a.fault)
    );

    traffic_sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_LIMIT    (STUCK_LIMIT)
    ) u_chan_b (
        .clk  (clk),
        .rstb (rstb),
        .raw  (sensor_b_raw),
        .serve(serve_b),
        .req  (st_b.req),
        .fault(st_b.fault)
    );

    assign input_a = st_a.req;
    assign fault_a = st_a.fault;
    assign input_b = st_b.req;
    assign fault_b = st_b.fault;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed and reference-model checks for traffic_sensor_conditioner
// (DEBOUNCE_CYCLES=4, STUCK_LIMIT=16).
module tb_traffic_sensor_conditioner;

    localparam int DEB = 4;
    localparam int STK = 16;

    logic clk = 1'b0;
    logic rstb;
    logic sensor_a_raw, sensor_b_raw, serve_a, serve_b;
    logic input_a, input_b, fault_a, fault_b;

    int n_asrt = 0;
    int n_fail = 0;

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .STUCK_LIMIT    (STK)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .sensor_a_raw(sensor_a_raw),
        .sensor_b_raw(sensor_b_raw),
        .serve_a     (serve_a),
        .serve_b     (serve_b),
        .input_a     (input_a),
        .input_b     (input_b),
        .fault_a     (fault_a),
        .fault_b     (fault_b)
    );

    always #5 clk = ~clk;

    // Cycle-accurate reference model of both channels.
    bit [1:0] m_s1, m_s2, m_deb, m_req, m_fault;
    int       m_dcnt [2];
    int       m_scnt [2];

    always @(posedge clk or negedge rstb) begin
        bit rw, sv, nd;
        int ns;
        if (!rstb) begin
            m_s1    <= '0;
            m_s2    <= '0;
            m_deb   <= '0;
            m_req   <= '0;
            m_fault <= '0;
            for (int c = 0; c < 2; c++) begin
                m_dcnt[c] <= 0;
                m_scnt[c] <= 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                rw = (c == 0) ? sensor_a_raw : sensor_b_raw;
                sv = (c == 0) ? serve_a : serve_b;
                nd = m_deb[c];
                if (m_s2[c] == m_deb[c]) m_dcnt[c] <= 0;
                else if (m_dcnt[c] == DEB - 1) begin
                    nd = m_s2[c];
                    m_dcnt[c] <= 0;
                end else m_dcnt[c] <= m_dcnt[c] + 1;
                if (nd && !m_deb[c]) m_req[c] <= 1'b1;
                else if (sv) m_req[c] <= 1'b0;
                ns = m_deb[c] ? ((m_scnt[c] < STK) ? m_scnt[c] + 1 : STK) : 0;
                if (!nd) m_fault[c] <= 1'b0;
                else if (m_deb[c] && ns == STK) m_fault[c] <= 1'b1;
                m_scnt[c] <= ns;
                m_deb[c]  <= nd;
                m_s2[c]   <= m_s1[c];
                m_s1[c]   <= rw;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstb = 1'b0;
        sensor_a_raw = 1'b0; sensor_b_raw = 1'b0;
        serve_a = 1'b0; serve_b = 1'b0;
        #2;
        chk("rst_input_a", input_a, 0);
        chk("rst_input_b", input_b, 0);
        chk("rst_fault_a", fault_a, 0);
        chk("rst_fault_b", fault_b, 0);
        tick(2);

        // Debounce latency on A
        rstb = 1'b1;
        sensor_a_raw = 1'b1;
        tick(5);
        chk("lat_a_edge5", input_a, 0);
        tick(1);
        chk("lat_a_edge6", input_a, 1);
        chk("lat_b_idle", input_b, 0);
        chk("lat_fault_a", fault_a, 0);

        // Asynchronous reset with a request pending
        #3;
        rstb = 1'b0;
        #1;
        chk("midrst_input_a", input_a, 0);
        chk("midrst_input_b", input_b, 0);
        chk("midrst_fault_a", fault_a, 0);
        chk("midrst_fault_b", fault_b, 0);
        tick(1);
        rstb = 1'b1;
        tick(5);
        chk("postrst_edge5", input_a, 0);
        tick(1);
        chk("postrst_edge6", input_a, 1);

        // 3-cycle glitch on B is rejected
        sensor_b_raw = 1'b1;
        tick(3);
        sensor_b_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("glitch_b", input_b, 0);
            tick(1);
        end

        // Serve clears, held car does not re-request
        serve_a = 1'b1;
        tick(1);
        serve_a = 1'b0;
        chk("serve_clear_a", input_a, 0);
        tick(3);
        chk("no_rereq_a", input_a, 0);
        sensor_a_raw = 1'b0;
        tick(10);
        chk("drop_a", input_a, 0);
        sensor_a_raw = 1'b1;
        tick(5);
        chk("rereq_a_edge5", input_a, 0);
        tick(1);
        chk("rereq_a_edge6", input_a, 1);
        chk("rereq_fault_a", fault_a, 0);

        // Set wins over a simultaneous serve
        serve_a = 1'b1;
        sensor_a_raw = 1'b0;
        tick(10);
        chk("serve_hold_a", input_a, 0);
        sensor_a_raw = 1'b1;
        tick(5);
        chk("setserve_edge5", input_a, 0);
        tick(1);
        chk("setserve_set", input_a, 1);
        tick(1);
        chk("setserve_clr", input_a, 0);
        serve_a = 1'b0;
        sensor_a_raw = 1'b0;
        tick(10);
        chk("idle_fault_a", fault_a, 0);

        // Stuck detect on B
        sensor_b_raw = 1'b1;
        tick(6);
        chk("stuck_req_b", input_b, 1);
        tick(15);
        chk("stuck_b_edge15", fault_b, 0);
        tick(1);
        chk("stuck_b_edge16", fault_b, 1);
        chk("stuck_req_kept", input_b, 1);
        chk("stuck_a_clean", fault_a, 0);
        sensor_b_raw = 1'b0;
        tick(5);
        chk("stuck_b_hold", fault_b, 1);
        tick(1);
        chk("stuck_b_clear", fault_b, 0);
        serve_b = 1'b1;
        tick(1);
        serve_b = 1'b0;

        // Random streams against the reference model
        for (int i = 0; i < 600; i++) begin
            chk("rnd_input_a", input_a, m_req[0]);
            chk("rnd_input_b", input_b, m_req[1]);
            chk("rnd_fault_a", fault_a, m_fault[0]);
            chk("rnd_fault_b", fault_b, m_fault[1]);
            if ($urandom_range(0, 19) == 0) sensor_a_raw = ~sensor_a_raw;
            if ($urandom_range(0, 14) == 0) sensor_b_raw = ~sensor_b_raw;
            serve_a = ($urandom_range(0, 7) == 0);
            serve_b = ($urandom_range(0, 7) == 0);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream stage of the traffic light FSM. It takes the raw, asynchronous vehicle-sensor levels for road A and road B and synchronises, debounces and latches them into clean request bits. Those bits drive the FSM's input_a and input_b. It also flags sensors that stay asserted abnormally long. Each road is cleared when the FSM signals that road has been served.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new raw level must hold before it is accepted (legal range 1..255).
STUCK_LIMIT, 1000, consecutive cycles of debounced-high after which a sensor is flagged stuck (legal range 2..65535).

Ports:
clk  input  1  system clock, all logic on rising edge
rstb  input  1  asynchronous active-low reset
sensor_a_raw  input  1  raw road-A vehicle sensor, asynchronous to clk
sensor_b_raw  input  1  raw road-B vehicle sensor, asynchronous to clk
serve_a  input  1  from FSM, high while road A has green; clears request A
serve_b  input  1  from FSM, high while road B has green; clears request B
input_a  output  1  latched road-A request to FSM
input_b  output  1  latched road-B request to FSM
fault_a  output  1  road-A sensor stuck-high flag
fault_b  output  1  road-B sensor stuck-high flag

Behaviour:
- Reset: on rstb low, immediately clear all of the following: sync flops, deb, counters, req, input_a/b and fault_a/b. Reset release is synchronous to the next rising edge. Reset asserted mid-debounce or mid-request discards all state.
- The two channels are identical and independent. The rules below are per channel x.
- Synchroniser: two-flop chain s1 <= raw, s2 <= s1. s2 is the only signal used downstream.
- Debounce: register deb plus counter dcnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == deb: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: deb <= s2 and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Latency: a raw change held steady changes deb on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples it. With the default this is the 6th edge.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes deb. The counter restarts on any return to equality.
- Request latch: rise = deb_next & ~deb, where deb_next is the value being loaded this edge.
  - req <= 1 when rise.
  - Else req <= 0 when serve_x.
  - Else req holds.
  - If rise and serve_x occur in the same cycle, set wins, so a newly arriving car is never lost.
  - A continuously present car does not re-request after being served; a new rising edge is needed.
  - input_x = req, registered, with no combinational path from any input.
- Stuck detect: counter scnt of width $clog2(STUCK_LIMIT+1).
  - While deb == 1, scnt increments and saturates at STUCK_LIMIT.
  - While deb == 0, scnt <= 0.
  - fault_x is registered and goes high on the edge where scnt becomes STUCK_LIMIT.
  - fault_x stays high until deb returns to 0, and clears on that same edge.
  - fault does not alter req.
- The outputs are glitch-free registers. There are no other side effects.

Decomposition:
- Package traffic_pkg:
  - default constants TL_DEBOUNCE_DEF=4 and TL_STUCK_DEF=1000;
  - a typedef struct for the per-channel status {req, fault}.
- Sub-module traffic_sensor_channel:
  - parameters DEBOUNCE_CYCLES and STUCK_LIMIT;
  - ports clk, rstb, raw, serve, req, fault;
  - instantiated twice, for A and B.
- The top level is only instantiation and port mapping.

Test Plan (DEBOUNCE_CYCLES=4, STUCK_LIMIT=16 for sim):
1. Reset check: assert rstb=0 mid-run with raw_a=1 and a req pending -> all outputs become 0 asynchronously. After release with raw held at 1, input_a rises on the 6th edge.
2. Debounce latency and glitch rejection:
   - raw_a 0->1 held -> input_a=1 exactly 6 edges after the sampling edge.
   - A raw_b pulse of 3 cycles -> input_b stays 0 throughout.
3. Serve clear and no re-request: input_a=1, then serve_a=1 for 1 cycle -> input_a=0 next edge. raw_a stays 1 -> input_a stays 0. raw_a drops for 10 cycles and then returns -> input_a=1 again.
4. Simultaneous set and serve: hold serve_a=1 across the edge where deb_a rises -> input_a=1 after that edge. It clears on the following edge, since serve is still high.
5. Stuck detect: raw_b held at 1 -> fault_b=1 exactly 16 edges after deb_b rises. raw_b dropped -> fault_b clears on the edge deb_b falls.
6. Channel independence: random raw_a/raw_b/serve streams against a cycle-accurate reference model -> input_a/b and fault_a/b match every cycle.
